// File: rtl/cl_frame_gen_pkg.sv
// Shared types for the Camera Link test-pattern transmitter: pixel width, beat phases,
// FSM states and the 3/3/4 beat-packing helper used by cl_pixel_pack.
package cl_frame_gen_pkg;

  localparam int CL_PIXEL_SIZE = 12;

  typedef enum logic [1:0] {
    CL_0 = 2'd0,
    CL_1 = 2'd1,
    CL_2 = 2'd2
  } cl_phase_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } fsm_state_e;

  // Ten 12-bit pixels are spread over three beats of five bytes; index 0 is port a (or f).
  function automatic logic [4:0][7:0] cl_pack_beat(input cl_phase_e ph,
                                                   input logic [9:0][CL_PIXEL_SIZE-1:0] p);
    logic [4:0][7:0] b;
    b = '0;
    case (ph)
      CL_0: begin
        b[0] = p[0][11:4];
        b[1] = {p[0][3:0], p[1][11:8]};
        b[2] = p[1][7:0];
        b[3] = p[2][11:4];
        b[4] = {p[2][3:0], p[3][11:8]};
      end
      CL_1: begin
        b[0] = p[3][7:0];
        b[1] = p[4][11:4];
        b[2] = {p[4][3:0], p[5][11:8]};
        b[3] = p[5][7:0];
        b[4] = p[6][11:4];
      end
      CL_2: begin
        b[0] = {p[6][3:0], p[7][11:8]};
        b[1] = p[7][7:0];
        b[2] = p[8][11:4];
        b[3] = {p[8][3:0], p[9][11:8]};
        b[4] = p[9][7:0];
      end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cl_frame_gen_pixel_pack.sv
// Registered beat packer: turns one phase worth of top/bottom pixels into the ten
// Camera Link port bytes; bytes are forced to zero when the line is not valid.
module cl_pixel_pack
  import cl_frame_gen_pkg::*;
(
  input  logic                             clk_85,
  input  logic                             reset,
  input  logic                             en,
  input  cl_phase_e                        phase,
  input  logic [9:0][CL_PIXEL_SIZE-1:0]    top_px,
  input  logic [9:0][CL_PIXEL_SIZE-1:0]    bot_px,
  output logic [4:0][7:0]                  top_bytes,
  output logic [4:0][7:0]                  bot_bytes
);

  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      top_bytes <= '0;
      bot_bytes <= '0;
    end else if (en) begin
      top_bytes <= cl_pack_beat(phase, top_px);
      bot_bytes <= cl_pack_beat(phase, bot_px);
    end else begin
      top_bytes <= '0;
      bot_bytes <= '0;
    end
  end

endmodule

// File: rtl/cl_frame_gen.sv
// Camera Link full-configuration frame transmitter driving a deterministic 12-bit
// test pattern; used as loopback source and as a stand-in for the camera model.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; all outputs low
// ST_SETUP  | FVAL high ahead of the first line (FV_SETUP clocks)
// ST_LINE   | LVAL high, one beat per clock (3*N_COL/10 clocks)
// ST_HBLANK | LVAL low between lines (H_BLANK clocks)
// ST_VBLANK | one FVAL trailer clock, then V_BLANK clocks with FVAL low
module cl_frame_gen
  import cl_frame_gen_pkg::*;
#(
  parameter int PIXEL_SIZE   = 12,
  parameter int N_COL        = 1280,
  parameter int N_ROW        = 1080,
  parameter int FV_SETUP     = 2,
  parameter int H_BLANK      = 16,
  parameter int V_BLANK      = 64,
  parameter int N_FRAME_SIZE = 20
) (
  input  logic                    clk_85,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N_FRAME_SIZE-1:0] n_frame,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    seq_done,
  output logic                    cl_fval,
  output logic                    cl_lval,
  output logic [7:0]              cl_port_a,
  output logic [7:0]              cl_port_b,
  output logic [7:0]              cl_port_c,
  output logic [7:0]              cl_port_d,
  output logic [7:0]              cl_port_e,
  output logic [7:0]              cl_port_f,
  output logic [7:0]              cl_port_g,
  output logic [7:0]              cl_port_h,
  output logic [7:0]              cl_port_i,
  output logic [7:0]              cl_port_j
);

  localparam logic [15:0] BEATS_M1   = 16'(3 * N_COL / 10 - 1);
  localparam logic [15:0] SETUP_M1   = 16'(FV_SETUP - 1);
  localparam logic [15:0] HBLANK_M1  = 16'(H_BLANK - 1);
  localparam logic [15:0] VBLANK_LEN = 16'(V_BLANK);
  localparam logic [15:0] LAST_ROW   = 16'(N_ROW - 1);

  fsm_state_e              state, state_n;
  cl_phase_e               phase, phase_n;
  logic [15:0]             timer, timer_n;
  logic [15:0]             col, col_n;
  logic [15:0]             row, row_n;
  logic [N_FRAME_SIZE-1:0] frame, frame_n;
  logic [N_FRAME_SIZE-1:0] total, total_n;
  logic                    last_row, last_frame, accept_zero, abort_hit;
  logic                    fval_d, lval_d, busy_d, frame_done_d, seq_done_d;

  logic [11:0]                  grp_off, base;
  logic [9:0][PIXEL_SIZE-1:0]   top_px, bot_px;
  logic [4:0][7:0]              top_bytes, bot_bytes;

  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= CL_0;
      timer      <= '0;
      col        <= '0;
      row        <= '0;
      frame      <= '0;
      total      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      seq_done   <= 1'b0;
      cl_fval    <= 1'b0;
      cl_lval    <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      timer      <= timer_n;
      col        <= col_n;
      row        <= row_n;
      frame      <= frame_n;
      total      <= total_n;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      seq_done   <= seq_done_d;
      cl_fval    <= fval_d;
      cl_lval    <= lval_d;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    timer_n     = timer;
    col_n       = col;
    row_n       = row;
    frame_n     = frame;
    total_n     = total;
    last_row    = (row == LAST_ROW);
    last_frame  = (frame + N_FRAME_SIZE'(1) == total);
    accept_zero = (state == ST_IDLE) && start && (n_frame == '0);
    abort_hit   = abort && (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (start && (n_frame != '0)) begin
          state_n = ST_SETUP;
          timer_n = SETUP_M1;
          frame_n = '0;
          row_n   = '0;
          total_n = n_frame;
        end
      end
      ST_SETUP: begin
        if (timer == '0) begin
          state_n = ST_LINE;
          timer_n = BEATS_M1;
          col_n   = '0;
          phase_n = CL_0;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      ST_LINE: begin
        if (timer == '0) begin
          if (last_row) begin
            state_n = ST_VBLANK;
            timer_n = VBLANK_LEN;
          end else begin
            state_n = ST_HBLANK;
            timer_n = HBLANK_M1;
            row_n   = row + 16'd1;
          end
        end else begin
          timer_n = timer - 16'd1;
          // pixel base advances 3/3/4 across the three beats of a group
          col_n   = col + ((phase == CL_2) ? 16'd4 : 16'd3);
          case (phase)
            CL_0:    phase_n = CL_1;
            CL_1:    phase_n = CL_2;
            default: phase_n = CL_0;
          endcase
        end
      end
      ST_HBLANK: begin
        if (timer == '0) begin
          state_n = ST_LINE;
          timer_n = BEATS_M1;
          col_n   = '0;
          phase_n = CL_0;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      ST_VBLANK: begin
        if (timer == '0) begin
          if (last_frame) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_SETUP;
            timer_n = SETUP_M1;
            frame_n = frame + N_FRAME_SIZE'(1);
            row_n   = '0;
          end
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (abort_hit) state_n = ST_IDLE;

    // outputs are registered from next-state so they line up with the state register
    busy_d       = (state_n != ST_IDLE);
    lval_d       = (state_n == ST_LINE);
    fval_d       = (state_n == ST_SETUP) || (state_n == ST_LINE) || (state_n == ST_HBLANK) ||
                   ((state == ST_LINE) && (state_n == ST_VBLANK));
    frame_done_d = (state == ST_VBLANK) && (timer == VBLANK_LEN) && !abort_hit;
    seq_done_d   = ((state == ST_VBLANK) && (timer == '0) && last_frame && !abort_hit) ||
                   accept_zero;
  end

  always_comb begin
    case (phase_n)
      CL_1:    grp_off = 12'd3;
      CL_2:    grp_off = 12'd6;
      default: grp_off = 12'd0;
    endcase
    base = 12'(frame_n) + 12'(row_n) + 12'(col_n) - grp_off;
    for (int i = 0; i < 10; i++) begin
      top_px[i] = base + 12'(i);
      bot_px[i] = ~top_px[i];
    end
  end

  cl_pixel_pack u_pack (
    .clk_85    (clk_85),
    .reset     (reset),
    .en        (lval_d),
    .phase     (phase_n),
    .top_px    (top_px),
    .bot_px    (bot_px),
    .top_bytes (top_bytes),
    .bot_bytes (bot_bytes)
  );

  assign cl_port_a = top_bytes[0];
  assign cl_port_b = top_bytes[1];
  assign cl_port_c = top_bytes[2];
  assign cl_port_d = top_bytes[3];
  assign cl_port_e = top_bytes[4];
  assign cl_port_f = bot_bytes[0];
  assign cl_port_g = bot_bytes[1];
  assign cl_port_h = bot_bytes[2];
  assign cl_port_i = bot_bytes[3];
  assign cl_port_j = bot_bytes[4];

endmodule
